// File: rtl/bit_serial_add_ctrl_pkg.sv
// bit_serial_add_ctrl_pkg: shared FSM state codes and default width for the bit-serial adder
//   DEF_WIDTH : default operand/result width
//   state_t   : sequencer states (the unused code 2'd3 recovers to ST_IDLE)
package bit_serial_add_ctrl_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// bit_serial_add_ctrl_if: request/result bundle between a requester and the bit-serial adder
//   start, abort, a, b, cin : requester -> adder (a, b, cin sampled only on accept)
//   ready, busy, done       : adder status (done is a one-cycle pulse)
//   sum, carry              : result, held until the next accept
interface bit_serial_add_ctrl_if
    import bit_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, abort, a, b, cin,
        input  ready, busy, done, sum, carry
    );

    modport slave (
        input  start, abort, a, b, cin,
        output ready, busy, done, sum, carry
    );
endinterface

// File: rtl/bit_serial_add_ctrl_cell.sv
// serial_add_cell: combinational 1-bit full adder built from two half adders
//   half_adder      : x, y -> s, c
//   serial_add_cell : a, b, ci -> s, co
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0, c0, c1;

    half_adder u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    // At most one of the two half-adder carries can be set, so OR merges them.
    assign co = c0 | c1;
endmodule

// File: rtl/bit_serial_add_ctrl.sv
// bit_serial_add_ctrl: adds two WIDTH-bit operands one bit per clock, LSB first, through one full-add cell
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bit_serial_add_ctrl_if.slave (start/abort/operands in, ready/busy/done/sum/carry out)
module bit_serial_add_ctrl
    import bit_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_serial_add_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last, bit_s, bit_co;

    assign accept = bus.start && bus.ready;
    assign last   = cnt == CNT_W'(WIDTH - 1);

    serial_add_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c_r),
        .s  (bit_s),
        .co (bit_co)
    );

    // Abort outranks completion on the last bit; the spare code 2'd3 falls back to idle.
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = bus.abort ? ST_IDLE : (last ? ST_DONE : ST_RUN);
            ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                sum_r <= '0;
                c_r   <= bus.cin;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                if (bus.abort) begin
                    sum_r <= '0;
                    c_r   <= 1'b0;
                    cnt   <= '0;
                end else begin
                    // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= {bit_s, sum_r[WIDTH-1:1]};
                    c_r   <= bit_co;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ready = (state == ST_IDLE) || (state == ST_DONE);
    assign bus.busy  = state == ST_RUN;
    assign bus.done  = state == ST_DONE;
    assign bus.sum   = sum_r;
    assign bus.carry = c_r;
endmodule
